register_pipe_m: RTL and testbench
==================================

Name: register_pipe_m

Overview:
- Parametrised multi-stage register pipeline, successor to the single enabled register.
- Carries WIDTH-bit data through DEPTH stages with a valid/ready handshake on both ends.
- Bubbles collapse, backpressure propagates stage by stage, and a synchronous flush empties the pipe.
- Sits between producer and consumer blocks as a timing-retiming or elastic stage with no data loss under stall.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 4, number of register stages (>=1).
- RESET_VAL, '0, value loaded into every stage data register on reset.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous clear of all stage valid bits.
- in_valid  input  1  producer presents in_data.
- in_ready  output  1  pipe accepts in_data this cycle.
- in_data  input  WIDTH  input payload.
- out_valid  output  1  last stage holds valid data.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  WIDTH  payload of last stage.
- occupancy  output  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH.

Behaviour:
- State and indexing:
  - Each stage k (0 = input side, DEPTH-1 = output side) has a valid bit v[k] and a data register r[k].
- Reset (rst_ low, asynchronous):
  - All v[k] = 0 and all r[k] = RESET_VAL.
  - Outputs during reset: out_valid=0, out_data=RESET_VAL, occupancy=0, in_ready=1 (unless flush is high).
- Advance rule (combinational chain from the output side):
  - adv[DEPTH-1] = out_ready or not v[DEPTH-1].
  - adv[k] = not v[k] or adv[k+1].
  - Stage k loads from stage k-1 (stage 0 loads from the input) when adv[k] is 1.
  - A loaded stage takes the source's data and valid bit. An invalid source writes v[k]=0, and r[k] may be left unchanged.
  - Stage k holds r[k] and v[k] when adv[k] is 0.
- Handshakes:
  - in_ready = adv[0] and not flush.
  - A transfer occurs on in_valid && in_ready and on out_valid && out_ready.
  - in_ready may depend combinationally on out_ready.
  - in_valid and in_data must not depend combinationally on in_ready.
  - Once a stage is valid and not advancing, its data must not change.
- Latency:
  - With out_ready held high and no flush, data accepted at edge N appears with out_valid=1 after edge N+DEPTH-1, i.e. DEPTH cycles of latency.
  - Throughput is one word per cycle.
- Bubble collapse:
  - An invalid stage always accepts, even when downstream is stalled.
  - A stalled pipe therefore fills to DEPTH words before in_ready drops.
- Full:
  - occupancy = DEPTH and out_ready = 0 gives in_ready = 0.
  - If out_ready = 1 while full, in_ready = 1 and the pipe shifts in the same cycle. Occupancy stays at DEPTH on a simultaneous in/out transfer.
- Empty:
  - out_valid = 0 and out_data holds its last value; the consumer must ignore it.
- Flush:
  - On the clock edge where flush = 1, all v[k] become 0 and r[k] hold their values. occupancy is 0 in the next cycle.
  - No input is accepted that cycle.
  - An output transfer in the flush cycle (out_valid && out_ready) still counts as delivered.
  - Flush has priority over all loads.
- Reset mid-operation:
  - Contents are lost immediately (asynchronous).
  - Normal operation resumes on the first rising edge after rst_ deasserts.
- occupancy:
  - Combinational popcount of v[]; it reflects the current register state, not the next.
- DEPTH = 1:
  - Degenerates to a single valid/ready register: in_ready = not v[0] or out_ready.

Test Plan:
- Stream, DEPTH=4, WIDTH=8, out_ready=1: send 0x01..0x08 on consecutive cycles -> out_data 0x01 has out_valid=1 four cycles after its acceptance, then 0x02..0x08 follow on consecutive cycles, and occupancy is steady at 4.
- Stall fill: out_ready=0, send 0xA0,0xA1,0xA2,0xA3,0xA4 -> the first four are accepted and in_ready drops with 0xA4 pending; occupancy=4; out_data=0xA0 held stable. Raise out_ready -> outputs are 0xA0..0xA4 in order with no loss or duplication.
- Bubble collapse: accept 0x11, idle 2 cycles, accept 0x22 with out_ready=0 -> 0x22 sits adjacent to 0x11, occupancy=2, in_ready stays 1.
- Flush: hold 3 words, assert flush for one cycle with in_valid=1 and in_data=0x55 -> in_ready=0 that cycle, occupancy=0 and out_valid=0 next cycle, 0x55 never appears at the output.
- Async reset: with 4 words in flight, pull rst_ low between edges -> out_valid=0, occupancy=0 and out_data=RESET_VAL immediately. Release rst_ and send 0x77 -> 0x77 emerges after 4 cycles.
- Random: random in_valid/out_ready at 50% for 10k cycles, checked against a scoreboard queue -> order preserved, no drops or duplicates, occupancy matches queue depth every cycle.

Source files
------------

// File: rtl/register_pipe_m_if.sv
// Valid/ready handshake bundle for register_pipe_m: producer side (in_*) and consumer side (out_*).
// The pipe connects through the slave modport and the surrounding logic through master.
interface register_pipe_m_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/register_pipe_m.sv
// Elastic DEPTH-stage register pipeline with valid/ready on both ends.
// Bubbles collapse, backpressure ripples back stage by stage, and flush drops all valid bits.
module register_pipe_m #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst_,
  input  logic                         flush,
  register_pipe_m_if.slave             bus,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] r [DEPTH];
  logic [DEPTH-1:0] adv;
  logic             tail_full;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] src_d [DEPTH];

  // A stage advances unless it and every stage downstream of it are full
  // while the consumer stalls; computed as a prefix AND to avoid a comb loop.
  always_comb begin
    adv       = '0;
    tail_full = 1'b1;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      tail_full = tail_full & v[k];
      adv[k]    = bus.out_ready | ~tail_full;
    end
  end

  always_comb begin
    src_v    = '0;
    src_v[0] = bus.in_valid;
    src_d[0] = bus.in_data;
    for (int k = 1; k < DEPTH; k++) begin
      src_v[k] = v[k-1];
      src_d[k] = r[k-1];
    end
  end

  // Data registers only load on a valid source, so an idle pipe keeps its last payload.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      v <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r[k] <= RESET_VAL;
      end
    end else if (flush) begin
      v <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (adv[k]) begin
          v[k] <= src_v[k];
          if (src_v[k]) begin
            r[k] <= src_d[k];
          end
        end
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occupancy = occupancy + OCC_W'(v[k]);
    end
  end

  assign bus.in_ready  = adv[0] & ~flush;
  assign bus.out_valid = v[DEPTH-1];
  assign bus.out_data  = r[DEPTH-1];

endmodule

// File: tb/tb_register_pipe_m.sv
// Directed table vectors, reset/flush/DEPTH=1 sequences and a scoreboarded random run for register_pipe_m.
module tb_register_pipe_m;

  localparam int               WIDTH     = 8;
  localparam int               DEPTH     = 4;
  localparam logic [WIDTH-1:0] RESET_VAL = 8'hC3;

  logic       clk = 1'b0;
  logic       rst_;
  logic       flush;
  logic       flush1;
  logic [2:0] occupancy;
  logic [0:0] occupancy1;

  int checks = 0;
  int errors = 0;

  register_pipe_m_if #(.WIDTH(WIDTH)) bus ();
  register_pipe_m_if #(.WIDTH(WIDTH)) bus1 ();

  register_pipe_m #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RESET_VAL)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy)
  );

  register_pipe_m #(.WIDTH(WIDTH), .DEPTH(1), .RESET_VAL(RESET_VAL)) dut1 (
    .clk       (clk),
    .rst_      (rst_),
    .flush     (flush1),
    .bus       (bus1),
    .occupancy (occupancy1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       flush;
    logic       exp_in_ready;
    logic       exp_out_valid;
    logic [7:0] exp_out_data;
    logic [2:0] exp_occ;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb[$];

  task automatic addVec(input logic iv, input logic [7:0] id, input logic ordy, input logic fl,
                        input logic e_ir, input logic e_ov, input logic [7:0] e_od, input logic [2:0] e_occ);
    vec_t t;
    t.in_valid = iv; t.in_data = id; t.out_ready = ordy; t.flush = fl;
    t.exp_in_ready = e_ir; t.exp_out_valid = e_ov; t.exp_out_data = e_od; t.exp_occ = e_occ;
    vecs.push_back(t);
  endtask

  task automatic applyStimulus(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    flush         = fl;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int wait_cycles;

    rst_ = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    flush1         = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.in_data   = 8'h00;
    bus1.out_ready = 1'b0;

    // Stream 0x01..0x08 with the consumer always ready
    addVec(1, 8'h01, 1, 0, 1, 0, 8'h00, 0);
    addVec(1, 8'h02, 1, 0, 1, 0, 8'h00, 1);
    addVec(1, 8'h03, 1, 0, 1, 0, 8'h00, 2);
    addVec(1, 8'h04, 1, 0, 1, 0, 8'h00, 3);
    addVec(1, 8'h05, 1, 0, 1, 1, 8'h01, 4);
    addVec(1, 8'h06, 1, 0, 1, 1, 8'h02, 4);
    addVec(1, 8'h07, 1, 0, 1, 1, 8'h03, 4);
    addVec(1, 8'h08, 1, 0, 1, 1, 8'h04, 4);
    addVec(0, 8'h00, 1, 0, 1, 1, 8'h05, 4);
    addVec(0, 8'h00, 1, 0, 1, 1, 8'h06, 3);
    addVec(0, 8'h00, 1, 0, 1, 1, 8'h07, 2);
    addVec(0, 8'h00, 1, 0, 1, 1, 8'h08, 1);
    addVec(0, 8'h00, 1, 0, 1, 0, 8'h00, 0);
    // Stall fill: four words accepted, 0xA4 waits until the consumer is ready
    addVec(1, 8'hA0, 0, 0, 1, 0, 8'h00, 0);
    addVec(1, 8'hA1, 0, 0, 1, 0, 8'h00, 1);
    addVec(1, 8'hA2, 0, 0, 1, 0, 8'h00, 2);
    addVec(1, 8'hA3, 0, 0, 1, 0, 8'h00, 3);
    addVec(1, 8'hA4, 0, 0, 0, 1, 8'hA0, 4);
    addVec(1, 8'hA4, 0, 0, 0, 1, 8'hA0, 4);
    addVec(1, 8'hA4, 1, 0, 1, 1, 8'hA0, 4);
    addVec(0, 8'h00, 1, 0, 1, 1, 8'hA1, 4);
    addVec(0, 8'h00, 1, 0, 1, 1, 8'hA2, 3);
    addVec(0, 8'h00, 1, 0, 1, 1, 8'hA3, 2);
    addVec(0, 8'h00, 1, 0, 1, 1, 8'hA4, 1);
    addVec(0, 8'h00, 1, 0, 1, 0, 8'h00, 0);
    // Bubble collapse: 0x22 catches up with the stalled 0x11
    addVec(1, 8'h11, 0, 0, 1, 0, 8'h00, 0);
    addVec(0, 8'h00, 0, 0, 1, 0, 8'h00, 1);
    addVec(0, 8'h00, 0, 0, 1, 0, 8'h00, 1);
    addVec(1, 8'h22, 0, 0, 1, 0, 8'h00, 1);
    addVec(0, 8'h00, 0, 0, 1, 1, 8'h11, 2);
    addVec(0, 8'h00, 0, 0, 1, 1, 8'h11, 2);
    addVec(0, 8'h00, 0, 0, 1, 1, 8'h11, 2);
    addVec(0, 8'h00, 1, 0, 1, 1, 8'h11, 2);
    addVec(0, 8'h00, 1, 0, 1, 1, 8'h22, 1);
    addVec(0, 8'h00, 1, 0, 1, 0, 8'h00, 0);
    // Flush with three words held and 0x55 offered in the flush cycle
    addVec(1, 8'h31, 0, 0, 1, 0, 8'h00, 0);
    addVec(1, 8'h32, 0, 0, 1, 0, 8'h00, 1);
    addVec(1, 8'h33, 0, 0, 1, 0, 8'h00, 2);
    addVec(1, 8'h55, 0, 1, 0, 0, 8'h00, 3);
    addVec(0, 8'h00, 1, 0, 1, 0, 8'h00, 0);
    addVec(0, 8'h00, 1, 0, 1, 0, 8'h00, 0);
    addVec(0, 8'h00, 1, 0, 1, 0, 8'h00, 0);
    addVec(0, 8'h00, 1, 0, 1, 0, 8'h00, 0);
    // Flush while the last stage is delivered to a ready consumer
    addVec(1, 8'h41, 0, 0, 1, 0, 8'h00, 0);
    addVec(0, 8'h00, 0, 0, 1, 0, 8'h00, 1);
    addVec(0, 8'h00, 0, 0, 1, 0, 8'h00, 1);
    addVec(0, 8'h00, 0, 0, 1, 0, 8'h00, 1);
    addVec(1, 8'h66, 1, 1, 0, 1, 8'h41, 1);
    addVec(0, 8'h00, 1, 0, 1, 0, 8'h00, 0);

    $display("[TB] reset state");
    #12;
    checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset occupancy", 32'(occupancy), 32'd0);
    checkOutput("reset out_data", 32'(bus.out_data), 32'(RESET_VAL));
    checkOutput("reset in_ready", 32'(bus.in_ready), 32'd1);
    flush = 1'b1;
    #1;
    checkOutput("reset in_ready with flush", 32'(bus.in_ready), 32'd0);
    flush = 1'b0;
    #4;
    rst_ = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed vectors: %0d", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready, vecs[i].flush);
      #1;
      checkOutput($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].exp_in_ready));
      checkOutput($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_out_valid));
      checkOutput($sformatf("vec%0d occupancy", i), 32'(occupancy), 32'(vecs[i].exp_occ));
      if (vecs[i].exp_out_valid) begin
        checkOutput($sformatf("vec%0d out_data", i), 32'(bus.out_data), 32'(vecs[i].exp_out_data));
      end
      @(posedge clk);
      #1;
    end

    $display("[TB] asynchronous reset mid-operation");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
      @(posedge clk);
      #1;
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    checkOutput("pre-reset occupancy", 32'(occupancy), 32'd4);
    #1;
    rst_ = 1'b0;
    #1;
    checkOutput("mid reset out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("mid reset occupancy", 32'(occupancy), 32'd0);
    checkOutput("mid reset out_data", 32'(bus.out_data), 32'(RESET_VAL));
    checkOutput("mid reset in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_ = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    wait_cycles = 1;
    while (!bus.out_valid && wait_cycles < 10) begin
      @(posedge clk);
      #1;
      wait_cycles++;
    end
    checkOutput("post-reset latency", 32'(wait_cycles), 32'd4);
    checkOutput("post-reset out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("post-reset out_data", 32'(bus.out_data), 32'h77);
    @(posedge clk);
    #1;

    $display("[TB] DEPTH=1 instance");
    bus1.in_valid = 1'b1; bus1.in_data = 8'hAA; bus1.out_ready = 1'b0;
    #1;
    checkOutput("d1 empty in_ready", 32'(bus1.in_ready), 32'd1);
    checkOutput("d1 empty occupancy", 32'(occupancy1), 32'd0);
    @(posedge clk);
    #1;
    bus1.in_data = 8'hBB;
    #1;
    checkOutput("d1 full stalled in_ready", 32'(bus1.in_ready), 32'd0);
    checkOutput("d1 full out_valid", 32'(bus1.out_valid), 32'd1);
    checkOutput("d1 full out_data", 32'(bus1.out_data), 32'hAA);
    checkOutput("d1 full occupancy", 32'(occupancy1), 32'd1);
    @(posedge clk);
    #1;
    bus1.out_ready = 1'b1;
    #1;
    checkOutput("d1 full ready in_ready", 32'(bus1.in_ready), 32'd1);
    checkOutput("d1 held out_data", 32'(bus1.out_data), 32'hAA);
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    #1;
    checkOutput("d1 swap out_data", 32'(bus1.out_data), 32'hBB);
    checkOutput("d1 swap occupancy", 32'(occupancy1), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("d1 drained out_valid", 32'(bus1.out_valid), 32'd0);
    checkOutput("d1 drained occupancy", 32'(occupancy1), 32'd0);
    bus1.out_ready = 1'b0;

    $display("[TB] random traffic against scoreboard");
    sb.delete();
    for (int c = 0; c < 10000; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      #1;
      checkOutput("rnd occupancy", 32'(occupancy), 32'(sb.size()));
      checkOutput("rnd in_ready", 32'(bus.in_ready), 32'((sb.size() < DEPTH) || bus.out_ready));
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("rnd spurious out_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          checkOutput("rnd out_data", 32'(bus.out_data), 32'(sb[0]));
          void'(sb.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(bus.in_data);
      end
      @(posedge clk);
      #1;
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    for (int c = 0; c < 4 * DEPTH && sb.size() > 0; c++) begin
      #1;
      if (bus.out_valid) begin
        checkOutput("drain out_data", 32'(bus.out_data), 32'(sb[0]));
        void'(sb.pop_front());
      end
      @(posedge clk);
      #1;
    end
    checkOutput("drain leftover words", 32'(sb.size()), 32'd0);
    #1;
    checkOutput("drain final occupancy", 32'(occupancy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
